mlp_seq_engine: RTL and testbench

//  Parametrised, time-multiplexed 2-layer MLP inference engine: N_IN inputs -> N_HID hidden -> 1 output, Q8.8 fixed point.

---
 rtl/mlp_seq_engine.sv | 189 ++++++++++++++++++
 tb/tb_mlp_seq_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: time-multiplexed N_IN -> N_HID -> 1 MLP, Q8.8, one shared MAC,
// runtime-loadable weight/bias register file, valid/ready on input and output.
module mlp_seq_engine #(
    parameter int N_IN  = 3,
    parameter int N_HID = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_wdata,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN*DW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_raw,
    output logic [DW-1:0]      out_result,
    output logic               busy
);

    localparam int DEPTH = N_HID*(N_IN+1) + N_HID + 1;
    localparam int NMAX  = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int CNW   = (NMAX  > 1) ? $clog2(NMAX)  : 1;
    localparam int HIW   = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int XW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HMAC = 3'd1;
    localparam logic [2:0] S_HACT = 3'd2;
    localparam logic [2:0] S_OMAC = 3'd3;
    localparam logic [2:0] S_OACT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW:0]      ONEX = (DW+1)'(1 << FRAC);
    localparam logic signed [DW:0]      HALFX = (DW+1)'(1 << (FRAC-1));
    localparam logic [DW-1:0]           ONE  = DW'(1 << FRAC);
    localparam logic [DW-1:0]           HALF = DW'(1 << (FRAC-1));

    logic [2:0]                state;
    logic [CNW-1:0]            cnt;
    logic [HIW-1:0]            h;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DW-1:0]      wmem [DEPTH];
    logic signed [DW-1:0]      hid  [N_HID];
    logic signed [DW-1:0]      x    [N_IN];
    logic [AW-1:0]             waddr;
    logic [AW-1:0]             baddr;
    logic signed [DW-1:0]      mac_a;
    logic signed [DW-1:0]      mac_b;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [DW-1:0]      act_y;
    logic                      last_h;

    // arithmetic shift by FRAC, clamp to the signed DW range
    function automatic logic signed [DW-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC;
        if (s > SMAX)      s = SMAX;
        else if (s < SMIN) s = SMIN;
        return s[DW-1:0];
    endfunction

    // hard sigmoid: clamp(0.5 + x/4, 0, 1)
    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v);
        logic signed [DW:0] y;
        y = $signed({v[DW-1], v}) >>> 2;
        y = y + HALFX;
        if (y < 0)         y = '0;
        else if (y > ONEX) y = ONEX;
        return y[DW-1:0];
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign last_h    = (h == HIW'(N_HID-1));

    // shared MAC operand selection and bias address for the next accumulation
    always_comb begin
        waddr = '0;
        baddr = '0;
        mac_b = '0;
        case (state)
            S_IDLE: baddr = AW'(N_IN);
            S_HMAC: begin
                waddr = AW'(h) * AW'(N_IN+1) + AW'(cnt);
                mac_b = x[cnt[XW-1:0]];
            end
            S_HACT: baddr = last_h ? AW'(DEPTH-1)
                                   : (AW'(h) + AW'(1)) * AW'(N_IN+1) + AW'(N_IN);
            S_OMAC: begin
                waddr = AW'(N_HID*(N_IN+1)) + AW'(cnt);
                mac_b = hid[cnt[HIW-1:0]];
            end
            default: ;
        endcase
        mac_a    = wmem[waddr];
        prod     = mac_a * mac_b;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W-DW-FRAC){wmem[baddr][DW-1]}}, wmem[baddr], {FRAC{1'b0}}};
        act_y    = act(sat(acc));
    end

    // weight/bias register file; writes only land while idle and in range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) wmem[k] <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (state == S_IDLE && {1'b0, cfg_addr} < (AW+1)'(DEPTH))
                    wmem[cfg_addr] <= cfg_wdata;
                else
                    cfg_err <= 1'b1;
            end
        end
    end

    // sequencer: hidden neurons one at a time, then the output neuron
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            h          <= '0;
            acc        <= '0;
            out_raw    <= '0;
            out_result <= '0;
            for (int unsigned k = 0; k < N_HID; k++) hid[k] <= '0;
            for (int unsigned k = 0; k < N_IN; k++)  x[k]   <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    for (int unsigned k = 0; k < N_IN; k++) x[k] <= in_data[k*DW +: DW];
                    acc   <= bias_ext;
                    h     <= '0;
                    cnt   <= '0;
                    state <= S_HMAC;
                end
                S_HMAC: begin
                    acc <= acc + prod_ext;
                    if (cnt == CNW'(N_IN-1)) begin
                        cnt   <= '0;
                        state <= S_HACT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HACT: begin
                    hid[h] <= act_y;
                    acc    <= bias_ext;
                    if (last_h) begin
                        state <= S_OMAC;
                    end else begin
                        h     <= h + 1'b1;
                        state <= S_HMAC;
                    end
                end
                S_OMAC: begin
                    acc <= acc + prod_ext;
                    if (cnt == CNW'(N_HID-1)) begin
                        cnt   <= '0;
                        state <= S_OACT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OACT: begin
                    out_raw    <= act_y;
                    out_result <= ($unsigned(act_y) > HALF) ? ONE : '0;
                    state      <= S_DONE;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed testbench for mlp_seq_engine with hand-computed expected values.
module tb_mlp_seq_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_raw;
    logic [15:0] out_result;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int acc_cyc;
    int lat;

    mlp_seq_engine #(.N_IN(3), .N_HID(4), .DW(16), .FRAC(8), .ACC_W(40), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_raw(out_raw), .out_result(out_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // free-running edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [15:0] d, input logic exp_err);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        chk($sformatf("cfg_err@%0d", a), {31'b0, cfg_err}, {31'b0, exp_err});
    endtask

    task automatic start_sample(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk("in_ready_before_start", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = {x2, x1, x0};
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        lat = cyc - acc_cyc;
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_sample(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                              input logic [15:0] x2, input logic [15:0] er, input logic [15:0] eres);
        start_sample(x0, x1, x2);
        wait_valid();
        chk({tag, "_latency"}, lat, 32'd21);
        chk({tag, "_raw"}, {16'b0, out_raw}, {16'b0, er});
        chk({tag, "_result"}, {16'b0, out_result}, {16'b0, eres});
        tick();
        chk({tag, "_idle_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_in_ready",   {31'b0, in_ready},  32'd1);
        chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("rst_out_raw",    {16'b0, out_raw},   32'd0);
        chk("rst_out_result", {16'b0, out_result},32'd0);
        chk("rst_cfg_err",    {31'b0, cfg_err},   32'd0);
        chk("rst_busy",       {31'b0, busy},      32'd0);

        // 1: all-zero network
        run_sample("t1", 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000);

        // 2: output bias only
        cfg_write(5'd20, 16'h0100, 1'b0);
        run_sample("t2", 16'h0123, 16'h0456, 16'h0789, 16'h00C0, 16'h0100);
        cfg_write(5'd20, 16'h0000, 1'b0);

        // 3: single path h0/i0 -> out
        cfg_write(5'd0,  16'h0100, 1'b0);
        cfg_write(5'd16, 16'h0100, 1'b0);
        run_sample("t3", 16'h0100, 16'h0000, 16'h0000, 16'h00B0, 16'h0100);

        // 4: hidden saturation
        cfg_write(5'd0, 16'h7FFF, 1'b0);
        run_sample("t4", 16'h7FFF, 16'h0000, 16'h0000, 16'h00C0, 16'h0100);

        // 5: back-pressure, same network as 4
        out_ready = 1'b0;
        start_sample(16'h7FFF, 16'h0000, 16'h0000);
        wait_valid();
        chk("t5_latency", lat, 32'd21);
        in_valid = 1'b1;
        in_data  = {16'h0, 16'h0, 16'h0100};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t5_hold_raw",   {16'b0, out_raw},   32'h00C0);
            chk("t5_hold_ready", {31'b0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t5_in_ready_after", {31'b0, in_ready},  32'd1);
        chk("t5_valid_dropped",  {31'b0, out_valid}, 32'd0);

        // 6a: write while busy is dropped (out bias stays 0), bad address dropped
        start_sample(16'h0100, 16'h0000, 16'h0000);
        tick();
        cfg_write(5'd20, 16'h0100, 1'b1);
        tick();
        chk("t6_err_pulse_end", {31'b0, cfg_err}, 32'd0);
        wait_valid();
        chk("t6_busy_raw", {16'b0, out_raw}, 32'h00C0);
        tick();
        cfg_write(5'd21, 16'h0100, 1'b1);
        cfg_write(5'd0,  16'h0100, 1'b0);
        run_sample("t6_after", 16'h0100, 16'h0000, 16'h0000, 16'h00B0, 16'h0100);

        // 6b: reset mid-sample aborts and clears weights
        start_sample(16'h0100, 16'h0000, 16'h0000);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("t6_no_valid_after_rst", seen, 32'd0);
        run_sample("t6_rst", 16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
